// File: rtl/tone_pkg.sv
// Shared types and constants for the tone burst generator.
package tone_pkg;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  localparam int unsigned MIN_DIV = 2;

endpackage

// File: rtl/tone_period_counter.sv
// Mod-n period counter producing the registered half-phase square wave.
module tone_period_counter
  import tone_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_run,
  input  logic [WIDTH-1:0] i_n,
  output logic [WIDTH-1:0] o_cnt,
  output logic             o_wrap,
  output logic             o_tone
);

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] w_cnt_inc;
  logic             r_tone;

  assign w_cnt_inc = r_cnt + WIDTH'(1);
  assign o_wrap    = (r_cnt == i_n - WIDTH'(1));
  assign o_cnt     = r_cnt;
  assign o_tone    = r_tone;

  // Tone is computed from the next count so it lines up with r_cnt after the edge.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_cnt  <= '0;
      r_tone <= 1'b0;
    end else if (!i_run || o_wrap) begin
      r_cnt  <= '0;
      r_tone <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_inc;
      r_tone <= (w_cnt_inc >= (i_n >> 1));
    end
  end

endmodule

// File: rtl/tone_burst_divider.sv
// Tone burst generator: FSM, burst-length counter and divisor shadow register
// around a mod-n period counter.
module tone_burst_divider
  import tone_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DUR_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] n_div,
  input  logic [DUR_W-1:0] duration,
  output logic             tone_out,
  output logic             busy,
  output logic             done,
  output logic             rejected
);

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_n_act, w_n_act_nxt;
  logic [DUR_W-1:0] r_periods_left, w_periods_nxt;
  logic             r_done, w_done_nxt;
  logic             r_rejected, w_rej_nxt;
  logic             w_n_ok, w_dur_ok, w_run, w_wrap, w_tone;
  logic [WIDTH-1:0] w_cnt;

  assign w_n_ok   = (n_div >= WIDTH'(MIN_DIV));
  assign w_dur_ok = (duration != '0);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state        <= IDLE;
      r_n_act        <= '0;
      r_periods_left <= '0;
      r_done         <= 1'b0;
      r_rejected     <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_n_act        <= w_n_act_nxt;
      r_periods_left <= w_periods_nxt;
      r_done         <= w_done_nxt;
      r_rejected     <= w_rej_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_n_act_nxt   = r_n_act;
    w_periods_nxt = r_periods_left;
    w_done_nxt    = 1'b0;
    w_rej_nxt     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start && !stop) begin
          if (w_n_ok && w_dur_ok) begin
            w_state_nxt   = RUN;
            w_n_act_nxt   = n_div;
            w_periods_nxt = duration;
          end else begin
            w_rej_nxt = 1'b1;
          end
        end
      end
      RUN: begin
        if (stop) begin
          w_state_nxt = IDLE;
        end else if (w_wrap) begin
          if (r_periods_left == DUR_W'(1)) begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            // Pitch changes land only here, so every period is whole.
            w_periods_nxt = r_periods_left - DUR_W'(1);
            if (w_n_ok) w_n_act_nxt = n_div;
          end
        end
      end
    endcase
  end

  assign w_run = (r_state == RUN) && (w_state_nxt == RUN);

  tone_period_counter #(
    .WIDTH(WIDTH)
  ) u_period (
    .clk   (clk),
    .rst_n (rst_n),
    .i_run (w_run),
    .i_n   (r_n_act),
    .o_cnt (w_cnt),
    .o_wrap(w_wrap),
    .o_tone(w_tone)
  );

  assign tone_out = w_tone;
  assign busy     = (r_state == RUN);
  assign done     = r_done;
  assign rejected = r_rejected;

  a_cnt_in_range : assert property (@(posedge clk) disable iff (rst_n)
    (r_state == RUN) |-> (w_cnt < r_n_act));

endmodule

// File: tb/tb_tone_burst_divider.sv
// Directed bench for tone_burst_divider; outputs checked as {tone_out,busy,done,rejected}.
module tb_tone_burst_divider;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic [31:0] n_div;
  logic [15:0] duration;
  logic        tone_out;
  logic        busy;
  logic        done;
  logic        rejected;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [0:7]  pat8;
  logic [0:4]  pat5;
  logic [0:15] pat16;

  tone_burst_divider #(
    .WIDTH(32),
    .DUR_W(16)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .stop    (stop),
    .n_div   (n_div),
    .duration(duration),
    .tone_out(tone_out),
    .busy    (busy),
    .done    (done),
    .rejected(rejected)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_o(input string tag, input logic [3:0] exp);
    logic [3:0] got;
    got = {tone_out, busy, done, rejected};
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: {tone,busy,done,rej} observed %b expected %b", tag, got, exp);
    end
  endtask

  initial begin
    rst_n = 1'b1; start = 1'b0; stop = 1'b0; n_div = '0; duration = '0;
    #12;
    check_o("reset", 4'b0000);
    rst_n = 1'b0;
    tick;
    check_o("idle after reset", 4'b0000);

    // Test 1: N=4, two periods
    pat8 = 8'b00110011;
    n_div = 32'd4; duration = 16'd2; start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check_o($sformatf("t1 cyc%0d", i), {pat8[i], 1'b1, 2'b00});
      tick;
    end
    check_o("t1 done", 4'b0010);
    tick;
    check_o("t1 idle", 4'b0000);

    // Test 2: odd N=5, one period
    pat5 = 5'b00111;
    n_div = 32'd5; duration = 16'd1; start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_o($sformatf("t2 cyc%0d", i), {pat5[i], 1'b1, 2'b00});
      tick;
    end
    check_o("t2 done", 4'b0010);
    tick;
    check_o("t2 idle", 4'b0000);

    // Test 3: pitch change mid-period, invalid divisor at boundary, duration change ignored
    pat16 = 16'b0011000111000111;
    n_div = 32'd4; duration = 16'd3; start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check_o($sformatf("t3 cyc%0d", i), {pat16[i], 1'b1, 2'b00});
      if (i == 1) n_div = 32'd6;
      if (i == 2) duration = 16'd1;
      if (i == 6) n_div = 32'd1;
      tick;
    end
    check_o("t3 done", 4'b0010);
    tick;
    check_o("t3 idle", 4'b0000);

    // Test 4: rejected starts and start with stop
    n_div = 32'd1; duration = 16'd3; start = 1'b1;
    tick;
    start = 1'b0;
    check_o("t4 rej ndiv", 4'b0001);
    tick;
    check_o("t4 rej ndiv clear", 4'b0000);
    n_div = 32'd4; duration = 16'd0; start = 1'b1;
    tick;
    start = 1'b0;
    check_o("t4 rej dur", 4'b0001);
    tick;
    check_o("t4 rej dur clear", 4'b0000);
    n_div = 32'd4; duration = 16'd2; start = 1'b1; stop = 1'b1;
    tick;
    start = 1'b0; stop = 1'b0;
    check_o("t4 start+stop", 4'b0000);
    tick;
    check_o("t4 start+stop idle", 4'b0000);

    // Test 5: stop mid-burst, stop on completion edge, async reset
    n_div = 32'd4; duration = 16'd4; start = 1'b1;
    tick;
    start = 1'b0;
    check_o("t5 c0", 4'b0100);
    tick;
    check_o("t5 c1", 4'b0100);
    tick;
    check_o("t5 c2", 4'b1100);
    stop = 1'b1;
    tick;
    stop = 1'b0;
    check_o("t5 stop", 4'b0000);
    tick;
    check_o("t5 no done", 4'b0000);

    n_div = 32'd2; duration = 16'd1; start = 1'b1;
    tick;
    start = 1'b0;
    check_o("t5b c0", 4'b0100);
    tick;
    check_o("t5b c1", 4'b1100);
    stop = 1'b1;
    tick;
    stop = 1'b0;
    check_o("t5b stop at end", 4'b0000);
    tick;
    check_o("t5b no done", 4'b0000);

    n_div = 32'd4; duration = 16'd4; start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    check_o("t5c pre-reset", 4'b1100);
    #2;
    rst_n = 1'b1;
    #1;
    check_o("t5c async reset", 4'b0000);
    #3;
    rst_n = 1'b0;
    tick;
    check_o("t5c after reset", 4'b0000);
    tick;
    check_o("t5c still idle", 4'b0000);

    // Test 6: start held high, back-to-back bursts
    n_div = 32'd2; duration = 16'd1; start = 1'b1;
    tick;
    check_o("t6 b1 c0", 4'b0100);
    tick;
    check_o("t6 b1 c1", 4'b1100);
    tick;
    check_o("t6 b1 done", 4'b0010);
    tick;
    check_o("t6 b2 c0", 4'b0100);
    tick;
    check_o("t6 b2 c1", 4'b1100);
    tick;
    check_o("t6 b2 done", 4'b0010);
    start = 1'b0;
    tick;
    check_o("t6 idle", 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tone_burst_divider.md
Name: tone_burst_divider

Overview:
Parametrised audio tone generator for the taximeter buzzer path. It is the next generation of the single-clock-divider tone source. It divides clk by a programmable divisor and emits a registered square wave for a programmed number of output periods, then reports completion. Divisor changes are accepted mid-burst but applied only at period boundaries (glitch-free pitch change). A stop input aborts the burst.

Parameters:
WIDTH, 32, width of divisor and period counter.
DUR_W, 16, width of the burst-length (output period count) field.

Ports:
clk  in  1  system clock; all logic on rising edge only.
rst_n  in  1  reset, asynchronous, active-high (port name kept per codebase).
start  in  1  request a burst; sampled in IDLE only.
stop  in  1  abort current burst; priority over start.
n_div  in  WIDTH  divisor N; valid range 2..2^WIDTH-1.
duration  in  DUR_W  number of tone periods in the burst; valid range >=1.
tone_out  out  1  registered square wave.
busy  out  1  high while a burst is running.
done  out  1  one-cycle pulse when a burst completes normally.
rejected  out  1  one-cycle pulse when start carries n_div<2 or duration==0.

Behaviour:
- Reset (async, rst_n=1): state=IDLE, cnt=0, n_act=0, periods_left=0. Outputs tone_out=0, busy=0, done=0, rejected=0, all immediately. Reset mid-burst aborts it with no done pulse.
- States: IDLE, RUN.
- IDLE, start=1, stop=0, n_div>=2, duration>=1 at edge k:
  - Latch n_act=n_div, periods_left=duration, cnt=0.
  - RUN from edge k. busy=1 and tone_out=0 are visible after edge k.
- IDLE, start=1 with n_div<2 or duration==0: stay IDLE; rejected=1 for the cycle after edge k.
- IDLE, start with stop=1: ignored, no pulse.
- RUN counting:
  - cnt counts 0..n_act-1 and wraps (mod-n_act).
  - tone_out is registered and equals (cnt >= n_act>>1) for the current cnt. Low for N>>1 cycles, then high for N-(N>>1) cycles.
  - Even N gives 50% duty. Odd N gives a high phase one clk longer than the low phase.
- Period boundary: an edge where cnt==n_act-1.
  - If periods_left>1: periods_left decrements, cnt=0.
  - At the same edge n_act takes the current n_div if n_div>=2; otherwise it keeps the old value and rejected is not pulsed.
  - n_div changes between boundaries have no effect.
- Completion: boundary with periods_left==1 → IDLE, busy=0, tone_out=0, done=1 for exactly one cycle.
  - busy is therefore high for exactly the sum of the n_act of each period. With a constant divisor this is N*duration cycles.
- stop=1 in RUN at any edge, including the completion edge → IDLE next edge, tone_out=0, busy=0, no done.
- start while RUN: ignored. start in the cycle done is high is accepted, allowing back-to-back bursts with one idle cycle.
- duration is latched only at start. Changes during RUN are ignored.
- Arithmetic: cnt, n_act are WIDTH bits unsigned; compares are unsigned. periods_left is DUR_W bits. No wrap past n_act-1 is possible since n_act>=2 is guaranteed.
- done and rejected are mutually exclusive. busy and done are never high in the same cycle.

Decomposition:
- Package tone_pkg:
  - state enum {IDLE, RUN}.
  - constant MIN_DIV=2.
- Sub-module tone_period_counter:
  - Mod-n counter with load/clear.
  - Outputs: cnt, a wrap flag (cnt==n-1), and the registered half-phase compare.
- The top module holds the FSM, the periods_left counter and the divisor shadow register.

Test Plan:
1. n_div=4, duration=2, start pulse → tone_out 0,0,1,1,0,0,1,1. busy high 8 cycles, done pulse on cycle 9, tone_out=0 after.
2. n_div=5, duration=1 → tone_out 0,0,1,1,1 (low 2, high 3). done after 5 busy cycles.
3. n_div=4, duration=3; n_div changed to 6 at cycle 2 of period 1 → period 1 stays 4 cycles; periods 2–3 are 6 cycles each (0,0,0,1,1,1). busy=16 cycles.
4. start with n_div=1 → rejected pulse, busy stays 0. start with duration=0 → rejected pulse.
5. stop asserted at cycle 3 of a 4×4 burst → busy=0 and tone_out=0 next cycle, no done. Async rst_n mid-burst → all outputs 0 immediately.
6. start held high continuously, n_div=2, duration=1 → bursts of 2 busy cycles separated by one done cycle. Repeated start during RUN has no effect.
